div_seq_ctrl: RTL and testbench
===============================

// Module: div_seq_ctrl
// PURPOSE
//  Sequencer for an iterative radix-2 divider serving RV32M DIV/DIVU/REM/REMU in EX.
//  Holds the pipeline while the operation runs: o_stall drives the same freeze as the hazard stall.
//  Freeze = PC hold, IF/ID and ID/EX hold.
//  Special cases (divide by zero, signed overflow) resolve in one cycle without iterating.
// PARAMETERS
//  XLEN    32  operand/result width
//  CNT_W   $clog2(XLEN)  iteration counter width (derived, not overridden)
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     reset, asynchronous, active-high
//  i_start   in   1     EX holds a valid divide instr; held high by pipeline while o_stall=1
//  i_op      in   2     funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  i_rs1     in   XLEN  dividend (sampled only on accept)
//  i_rs2     in   XLEN  divisor (sampled only on accept)
//  i_kill    in   1     abort current op (trap/redirect); wins over everything but rst
//  o_stall   out  1     freeze PC/IF/ID/EX this cycle
//  o_valid   out  1     o_result valid this cycle (1-cycle pulse, registered)
//  o_result  out  XLEN  quotient or remainder per latched op
//  o_busy    out  1     state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, cnt=0, o_valid=0, o_result=0, all datapath regs 0.
//  States: IDLE, CALC, FIX, DONE.
//  IDLE: i_start=1 -> accept: latch op, |rs1|,|rs2| (abs only for DIV/REM), signs.
//   - rs2==0 or (signed and rs1=0x80000000, rs2=0xFFFFFFFF): load special result -> DONE.
//   - otherwise: rem=0, quo=|rs1|, cnt=0 -> CALC.
//  CALC: one restoring step per cycle on {rem,quo}<<1.
//   - Trial subtract is XLEN+1 bits; set quo LSB if non-negative.
//   - cnt increments; at cnt==XLEN-1 -> FIX (exactly XLEN cycles in CALC).
//  FIX: apply signs (quotient neg if sign1^sign2; remainder takes sign1).
//   - Select quo/rem by op into o_result -> DONE.
//  DONE: o_valid=1, o_stall=0; pipeline advances this edge -> IDLE.
//  o_stall (comb) = (IDLE & i_start & ~i_kill) | CALC | FIX.
//  Latency: normal 34 stall cycles, result on cycle 35. Special: 1 stall cycle, result on cycle 2.
//  Special results: x/0 -> quotient 0xFFFFFFFF (DIV and DIVU), remainder = rs1.
//  Overflow: DIV -> 0x80000000, REM -> 0.
//  Back-to-back: i_start=1 in the IDLE cycle after DONE is a new instr; accepted normally.
//  i_kill any state: next edge -> IDLE, no o_valid, o_stall=0 in the kill cycle.
//   - Kill in DONE suppresses nothing already registered; o_valid still shows that cycle.
//  i_start dropping in CALC/FIX (not allowed by pipeline) is ignored; op completes.
//  rst mid-op: immediate IDLE, outputs to reset values, no o_valid.
//  Operands are never re-read after accept; o_result holds until next accept.
// TESTING
//  DIVU 100/7: stall 34 cycles, then o_valid with o_result=14. REMU same -> 2.
//  DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIV 7/-2 -> -3.
//  DIVU 5/0 -> 0xFFFFFFFF after 1 stall cycle. REM 5/0 -> 5. REMU 0x80000000/0 -> 0x80000000.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000, 1 stall; REM same operands -> 0.
//  i_kill at CALC cnt=10 -> IDLE next cycle, o_valid never asserts.
//   - Next start 9/3 DIVU -> 3 after 34 stalls.
//  rst at CALC cnt=5 -> all outputs 0 immediately.
//  Back-to-back DIVU 20/4 then REMU 20/6 -> 5 then 2; each preceded by 34 stalls, no gap beyond DONE.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Sequencer and datapath for an iterative restoring radix-2 divider covering
// RV32M DIV/DIVU/REM/REMU. It freezes the pipeline through o_stall while an operation runs.
module div_seq_ctrl #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_kill,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   rem_reg, quo_reg, dvs_reg, result_reg;
    logic              sel_rem_reg, sign1_reg, neg_q_reg, valid_reg;

    logic              stall_raw, accept, fix_commit;

    // Operand decode for the accept cycle
    logic              is_signed, a_neg, b_neg, div_zero, overflow, special;
    logic [XLEN-1:0]   abs_a, abs_b, special_result;

    always_comb begin
        is_signed = ~i_op[0];
        a_neg     = is_signed & i_rs1[XLEN-1];
        b_neg     = is_signed & i_rs2[XLEN-1];
        abs_a     = a_neg ? -i_rs1 : i_rs1;
        abs_b     = b_neg ? -i_rs2 : i_rs2;
        div_zero  = (i_rs2 == '0);
        overflow  = is_signed & (i_rs1 == MIN_NEG) & (i_rs2 == '1);
        special   = div_zero | overflow;
        if (div_zero) begin
            special_result = i_op[1] ? i_rs1 : '1;
        end else begin
            special_result = i_op[1] ? '0 : MIN_NEG;
        end
    end

    // One restoring step: shift {rem,quo} left and trial-subtract with a guard bit
    logic [XLEN:0]     shifted, diff;
    logic [XLEN-1:0]   rem_step, quo_step, quo_fix, rem_fix;

    always_comb begin
        shifted = {rem_reg, quo_reg[XLEN-1]};
        diff    = shifted - {1'b0, dvs_reg};
        if (!diff[XLEN]) begin
            rem_step = diff[XLEN-1:0];
            quo_step = {quo_reg[XLEN-2:0], 1'b1};
        end else begin
            rem_step = shifted[XLEN-1:0];
            quo_step = {quo_reg[XLEN-2:0], 1'b0};
        end
        quo_fix = neg_q_reg ? -quo_reg : quo_reg;
        rem_fix = sign1_reg ? -rem_reg : rem_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stall_raw  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    accept     = 1'b1;
                    stall_raw  = 1'b1;
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                stall_raw = 1'b1;
                if (cnt_reg == CNT_W'(XLEN - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                stall_raw  = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Kill aborts from any state and releases the freeze in the same cycle
        if (i_kill) begin
            state_next = IDLE;
            stall_raw  = 1'b0;
            accept     = 1'b0;
        end
    end

    assign fix_commit = (state_reg == FIX) && !i_kill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            result_reg  <= '0;
            sel_rem_reg <= 1'b0;
            sign1_reg   <= 1'b0;
            neg_q_reg   <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            valid_reg <= (state_next == DONE);
            if (accept) begin
                sel_rem_reg <= i_op[1];
                sign1_reg   <= a_neg;
                neg_q_reg   <= a_neg ^ b_neg;
                rem_reg     <= '0;
                quo_reg     <= abs_a;
                dvs_reg     <= abs_b;
                cnt_reg     <= '0;
                if (special) begin
                    result_reg <= special_result;
                end
            end else if (state_reg == CALC && !i_kill) begin
                rem_reg <= rem_step;
                quo_reg <= quo_step;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else if (fix_commit) begin
                result_reg <= sel_rem_reg ? rem_fix : quo_fix;
            end
        end
    end

    // Reset must force every output low, including the combinational freeze
    assign o_stall  = stall_raw & ~rst;
    assign o_valid  = valid_reg;
    assign o_result = result_reg;
    assign o_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed vector table, kill/reset
// sequences and random operations against an arithmetic reference model.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_rs1, i_rs2;
    logic        i_kill;
    logic        o_stall, o_valid, o_busy;
    logic [31:0] o_result;

    int vec_count = 0;
    int miscompares = 0;

    div_seq_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_kill(i_kill),
        .o_stall(o_stall), .o_valid(o_valid), .o_result(o_result), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          stalls;
    } vec_t;

    vec_t vecs[16];

    // RV32M semantics from the ISA rules, using the simulator's own arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'b00:   return 32'($signed(a) / $signed(b));
            2'b01:   return a / b;
            2'b10:   return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_stalls(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vec_count++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Issue one divide, count stall cycles until o_valid, then release at the DONE edge
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_stalls, input bit drop);
        int  stalls = 0;
        bit  seen = 0;
        logic [31:0] res = 32'h0;
        i_op = op; i_rs1 = a; i_rs2 = b; i_start = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (o_valid) begin
                seen = 1;
                res = o_result;
                break;
            end
            if (o_stall) stalls++;
            // Operands are not re-read after accept, and a dropped start is ignored
            if (drop && c == 3) begin
                i_start = 1'b0;
                i_rs1 = $urandom;
                i_rs2 = $urandom;
            end
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check("valid_seen", 32'(seen), 32'd1);
        check("result", res, exp);
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        check("valid_pulse", 32'(o_valid), 32'd0);
        $display("op=%0d rs1=0x%08h rs2=0x%08h -> result=0x%08h (exp 0x%08h) stalls=%0d (exp %0d)",
                 op, a, b, res, exp, stalls, exp_stalls);
    endtask

    initial begin
        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         34};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          34};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
        vecs[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};
        vecs[5]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[6]  = '{2'b10, 32'd5,          32'd0,          32'd5,          1};
        vecs[7]  = '{2'b11, 32'h8000_0000,  32'd0,          32'h8000_0000,  1};
        vecs[8]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[9]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[10] = '{2'b01, 32'd20,         32'd4,          32'd5,          34};
        vecs[11] = '{2'b11, 32'd20,         32'd6,          32'd2,          34};
        vecs[12] = '{2'b00, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[13] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
        vecs[14] = '{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          34};
        vecs[15] = '{2'b10, 32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  34};

        rst = 1'b1; i_start = 1'b0; i_op = 2'b00; i_rs1 = '0; i_rs2 = '0; i_kill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", 32'(o_stall), 32'd0);
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_result", o_result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stalls, 1'b0);

        // Dropped start mid-operation still completes with the accepted operands
        run_op(2'b01, 32'd1000, 32'd9, 32'd111, 34, 1'b1);

        // Kill in CALC at cnt=10: freeze released in that cycle, no result ever
        begin
            bit valid_seen = 0;
            i_op = 2'b01; i_rs1 = 32'hFFFF_FFFF; i_rs2 = 32'd3; i_start = 1'b1;
            repeat (11) @(posedge clk);
            #1;
            check("kill_busy_before", 32'(o_busy), 32'd1);
            check("kill_stall_before", 32'(o_stall), 32'd1);
            i_kill = 1'b1; i_start = 1'b0;
            #1;
            check("kill_stall_cycle", 32'(o_stall), 32'd0);
            @(posedge clk);
            #1;
            i_kill = 1'b0;
            check("kill_busy_after", 32'(o_busy), 32'd0);
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (o_valid) valid_seen = 1;
            end
            check("kill_no_valid", 32'(valid_seen), 32'd0);
            $display("kill at cnt=10: busy=%0d valid_seen=%0d", o_busy, valid_seen);
            @(posedge clk);
            #1;
        end
        run_op(2'b01, 32'd9, 32'd3, 32'd3, 34, 1'b0);

        // Reset at CALC cnt=5 clears every output at once
        i_op = 2'b01; i_rs1 = 32'd100; i_rs2 = 32'd7; i_start = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_stall", 32'(o_stall), 32'd0);
        check("rst_mid_valid", 32'(o_valid), 32'd0);
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        check("rst_mid_result", o_result, 32'd0);
        $display("reset at cnt=5: stall=%0d valid=%0d busy=%0d result=0x%08h",
                 o_stall, o_valid, o_busy, o_result);
        i_start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            int          mode;
            op   = 2'($urandom_range(0, 3));
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(op, a, b, ref_div(op, a, b), ref_stalls(op, a, b), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
